// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush handling.
// Optional `ID_EX_PERF_EN adds stall and load-use bubble counters.
module id_ex_stage #(
  parameter int          CTRL_W   = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_wr_addr,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_rd,
  input  logic              id_reg_wr,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              wb_reg_wr,
  input  logic [4:0]        wb_wr_addr,
  input  logic [31:0]       wb_wr_data,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs_addr,
  output logic [4:0]        ex_rt_addr,
  output logic [4:0]        ex_wr_addr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_rd,
  output logic              ex_reg_wr,
  output logic              id_stall,
  output logic              load_use
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [4:0]        rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, wr_addr_q, wr_addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_rd_q, mem_rd_d, reg_wr_q, reg_wr_d;
  logic              rs_hit, rt_hit, wb_hit;

  // ex_mem_rd is already qualified by ex_valid, so it alone marks a load in EX.
  assign rs_hit   = id_uses_rs && (id_rs_addr == wr_addr_q);
  assign rt_hit   = id_uses_rt && (id_rt_addr == wr_addr_q);
  assign load_use = id_valid && valid_q && mem_rd_q && (wr_addr_q != 5'd0) &&
                    (rs_hit || rt_hit) && !flush;
  assign id_stall = ex_stall || load_use;
  assign wb_hit   = wb_reg_wr && (wb_wr_addr != 5'd0) && valid_q;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    wr_addr_d = wr_addr_q;
    ctrl_d    = ctrl_q;
    mem_rd_d  = mem_rd_q;
    reg_wr_d  = reg_wr_q;
    if (ex_stall) begin
      // Held operands track writeback so EX sees current values when it resumes.
      if (wb_hit && (wb_wr_addr == rs_addr_q)) rs_data_d = wb_wr_data;
      if (wb_hit && (wb_wr_addr == rt_addr_q)) rt_data_d = wb_wr_data;
    end else begin
      pc_d      = id_pc;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      wr_addr_d = id_wr_addr;
      ctrl_d    = id_ctrl;
      if (flush || load_use) begin
        valid_d  = 1'b0;
        mem_rd_d = 1'b0;
        reg_wr_d = 1'b0;
      end else begin
        valid_d  = id_valid;
        mem_rd_d = id_mem_rd && id_valid;
        reg_wr_d = id_reg_wr && id_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      wr_addr_q <= '0;
      ctrl_q    <= '0;
      mem_rd_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      wr_addr_q <= wr_addr_d;
      ctrl_q    <= ctrl_d;
      mem_rd_q  <= mem_rd_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_pc      = pc_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs_addr = rs_addr_q;
  assign ex_rt_addr = rt_addr_q;
  assign ex_wr_addr = wr_addr_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_mem_rd  = mem_rd_q;
  assign ex_reg_wr  = reg_wr_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  // Bubbles are counted only when the load-use path actually wins the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (id_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!ex_stall && load_use) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a transaction-level model of the EX latch.
// Build with +define+ID_EX_PERF_EN to also check the performance counters.
module tb_id_ex_stage;
  localparam int          CTRL_W   = 16;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs, id_uses_rt, id_mem_rd, id_reg_wr, flush, ex_stall, wb_reg_wr;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm, wb_wr_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr, wb_wr_addr;
  logic [CTRL_W-1:0] id_ctrl;
  logic ex_valid, ex_mem_rd, ex_reg_wr, id_stall, load_use;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_wr_addr;
  logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_addr(id_wr_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_rd(id_mem_rd), .id_reg_wr(id_reg_wr), .flush(flush), .ex_stall(ex_stall),
    .wb_reg_wr(wb_reg_wr), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_wr_addr(ex_wr_addr),
    .ex_ctrl(ex_ctrl), .ex_mem_rd(ex_mem_rd), .ex_reg_wr(ex_reg_wr),
    .id_stall(id_stall), .load_use(load_use)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference: what EX should currently hold; m_known is 0 after a bubble
  // because the payload fields are then don't-care.
  bit          m_valid, m_mem_rd, m_reg_wr, m_known;
  logic [31:0] m_pc, m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs_addr, m_rt_addr, m_wr_addr;
  logic [CTRL_W-1:0] m_ctrl;
  logic [31:0] m_stall_cnt, m_bubble_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, n_step);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_mem_rd = 0; m_reg_wr = 0; m_known = 1;
    m_pc = RESET_PC; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs_addr = 0; m_rt_addr = 0; m_wr_addr = 0; m_ctrl = '0;
    m_stall_cnt = 0; m_bubble_cnt = 0;
  endtask

  task automatic check_regs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_mem_rd", ex_mem_rd, m_mem_rd);
    chk("ex_reg_wr", ex_reg_wr, m_reg_wr);
    if (m_known) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs_data", ex_rs_data, m_rs_data);
      chk("ex_rt_data", ex_rt_data, m_rt_data);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rs_addr", ex_rs_addr, m_rs_addr);
      chk("ex_rt_addr", ex_rt_addr, m_rt_addr);
      chk("ex_wr_addr", ex_wr_addr, m_wr_addr);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
    end
`ifdef ID_EX_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
    chk("perf_bubble_cnt", perf_bubble_cnt, m_bubble_cnt);
`endif
  endtask

  // Called just after a falling edge with the ID-side inputs already set.
  task automatic step();
    bit hit, lu;
    #1;
    hit = (id_uses_rs && id_rs_addr == m_wr_addr) || (id_uses_rt && id_rt_addr == m_wr_addr);
    lu  = id_valid && m_valid && m_mem_rd && (m_wr_addr != 0) && hit && !flush;
    chk("load_use", load_use, lu);
    chk("id_stall", id_stall, ex_stall || lu);
    @(posedge clk);
    if (ex_stall || lu) m_stall_cnt++;
    if (!ex_stall && lu) m_bubble_cnt++;
    if (ex_stall) begin
      if (wb_reg_wr && wb_wr_addr != 0 && m_valid) begin
        if (wb_wr_addr == m_rs_addr) m_rs_data = wb_wr_data;
        if (wb_wr_addr == m_rt_addr) m_rt_data = wb_wr_data;
      end
    end else if (flush || lu) begin
      m_valid = 0; m_mem_rd = 0; m_reg_wr = 0; m_known = 0;
    end else begin
      m_valid = id_valid; m_mem_rd = id_mem_rd && id_valid; m_reg_wr = id_reg_wr && id_valid;
      m_pc = id_pc; m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
      m_rs_addr = id_rs_addr; m_rt_addr = id_rt_addr; m_wr_addr = id_wr_addr;
      m_ctrl = id_ctrl; m_known = 1;
    end
    #1;
    check_regs();
    $display("step %0d: stall=%0d flush=%0d lu=%0d -> ex_valid=%0d pc=%h", n_step, ex_stall,
             flush, lu, ex_valid, ex_pc);
    n_step++;
    @(negedge clk);
  endtask

  // Asserts reset away from any clock edge to exercise the asynchronous path.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("rst_pc", ex_pc, RESET_PC);
    $display("reset applied at step %0d", n_step);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_mem_rd = 0; id_reg_wr = 0;
    flush = 0; ex_stall = 0; wb_reg_wr = 0;
    id_pc = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; wb_wr_data = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_wr_addr = 0; wb_wr_addr = 0; id_ctrl = '0;
  endtask

  // Small register range so hazards and writeback matches happen often.
  task automatic rand_inputs();
    id_valid   = ($urandom_range(0, 9) < 8);
    id_pc      = $urandom;
    id_rs_addr = 5'($urandom_range(0, 3));
    id_rt_addr = 5'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom);
    id_uses_rt = 1'($urandom);
    id_wr_addr = 5'($urandom_range(0, 3));
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_ctrl    = CTRL_W'($urandom);
    id_mem_rd  = ($urandom_range(0, 9) < 4);
    id_reg_wr  = ($urandom_range(0, 9) < 6);
    flush      = ($urandom_range(0, 7) == 0);
    ex_stall   = ($urandom_range(0, 3) == 0);
    wb_reg_wr  = 1'($urandom);
    wb_wr_addr = 5'($urandom_range(0, 3));
    wb_wr_data = $urandom;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset while a valid instruction sits in EX.
    id_valid = 1; id_pc = 32'h100; id_reg_wr = 1; id_wr_addr = 5'd3; id_rs_data = 32'h55;
    step();
    chk("pre_rst_valid", ex_valid, 1);
    do_reset();
    chk("rst_valid", ex_valid, 0);
    chk("rst_rs_data", ex_rs_data, 0);

    // lw $8 followed by add reading $8: one bubble, then add enters EX.
    clear_inputs();
    id_valid = 1; id_pc = 32'h200; id_mem_rd = 1; id_reg_wr = 1; id_wr_addr = 5'd8;
    step();
    id_mem_rd = 0; id_pc = 32'h204; id_uses_rs = 1; id_rs_addr = 5'd8; id_wr_addr = 5'd9;
    #1;
    chk("lu_dir", load_use, 1);
    chk("lu_stall_dir", id_stall, 1);
    step();
    chk("lu_bubble", ex_valid, 0);
    step();
    chk("lu_reload", ex_valid, 1);
    chk("lu_reload_pc", ex_pc, 32'h204);

    // lw to $0 never creates a hazard.
    clear_inputs();
    id_valid = 1; id_pc = 32'h300; id_mem_rd = 1; id_reg_wr = 1; id_wr_addr = 5'd0;
    step();
    id_mem_rd = 0; id_pc = 32'h304; id_uses_rs = 1; id_rs_addr = 5'd0;
    #1;
    chk("r0_lu", load_use, 0);
    step();
    chk("r0_valid", ex_valid, 1);

    // Held operand picks up a writeback to its register.
    clear_inputs();
    id_valid = 1; id_pc = 32'h400; id_rs_addr = 5'd3; id_rt_addr = 5'd5;
    id_uses_rt = 1; id_rs_data = 32'h22; id_rt_data = 32'h11;
    step();
    ex_stall = 1; wb_reg_wr = 1; wb_wr_addr = 5'd5; wb_wr_data = 32'hDEADBEEF;
    step();
    chk("coh_rt", ex_rt_data, 32'hDEADBEEF);
    chk("coh_rs", ex_rs_data, 32'h22);

    // Stall beats flush; flush takes effect once EX advances.
    ex_stall = 1; wb_reg_wr = 0; flush = 1;
    step();
    chk("hold_valid", ex_valid, 1);
    ex_stall = 0;
    step();
    chk("flush_valid", ex_valid, 0);
    chk("flush_regwr", ex_reg_wr, 0);

`ifdef ID_EX_PERF_EN
    // Three load-use events plus two stall cycles.
    do_reset();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      id_valid = 1; id_uses_rs = 0; id_mem_rd = 1; id_reg_wr = 1; id_wr_addr = 5'd7;
      step();
      id_mem_rd = 0; id_uses_rs = 1; id_rs_addr = 5'd7; id_wr_addr = 5'd1;
      step();
      step();
    end
    ex_stall = 1;
    step();
    step();
    ex_stall = 0;
    chk("perf_bubble_dir", perf_bubble_cnt, 3);
    chk("perf_stall_dir", perf_stall_cnt, 5);
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        rand_inputs();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
